// File: rtl/mem_if_pkg.sv
// Shared types for the DCache posted-write buffer: entry layout, FSM encoding
// and the word-select boundary used for address matching.
package mem_if_pkg;
  localparam int WORD_LSB      = 2;
  localparam int WB_ADDR_WIDTH = 32;
  localparam int WB_DATA_WIDTH = 32;

  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] addr;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RSP  = 2'd3
  } wb_state_t;
endpackage

// File: rtl/dcache_write_buffer_if.sv
// Cache-side and memory-side handshake bundle of the write buffer.
// slave = the buffer itself, master = the surrounding cache/memory environment.
interface dcache_write_buffer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cache_read_request;
  logic                  cache_write_request;
  logic [ADDR_WIDTH-1:0] cache_addr;
  logic [DATA_WIDTH-1:0] cache_write_data;
  logic                  cache_response;
  logic [DATA_WIDTH-1:0] cache_read_data;
  logic                  mem_read_request;
  logic                  mem_write_request;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  mem_response;
  logic [DATA_WIDTH-1:0] mem_read_data;
  logic                  empty;

  modport slave (
    input  cache_read_request, cache_write_request, cache_addr, cache_write_data,
    input  mem_response, mem_read_data,
    output cache_response, cache_read_data,
    output mem_read_request, mem_write_request, mem_addr, mem_write_data,
    output empty
  );

  modport master (
    output cache_read_request, cache_write_request, cache_addr, cache_write_data,
    output mem_response, mem_read_data,
    input  cache_response, cache_read_data,
    input  mem_read_request, mem_write_request, mem_addr, mem_write_data,
    input  empty
  );
endinterface

// File: rtl/wb_fifo.sv
// Store queue for the write buffer. Exposes every slot plus its valid bit so the
// top can forward from entries that are queued or already in flight to memory.
module wb_fifo
  import mem_if_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wb_entry_t,
  localparam int PW      = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  entry_t               push_entry,
  input  logic                 pop,
  output logic                 full,
  output logic [PW:0]          count,
  output logic [PW-1:0]        head,
  output logic [DEPTH-1:0]     valid,
  output entry_t [DEPTH-1:0]   entries
);
  logic [PW-1:0]      tail;
  entry_t [DEPTH-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (pop)  head <= head + PW'(1);
      if (push) tail <= tail + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      // When full, head==tail: the push must win over the pop's clear.
      if (pop)  valid[head] <= 1'b0;
      if (push) valid[tail] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[tail] <= push_entry;
  end

  assign entries = mem_q;
  assign full    = (count == (PW+1)'(DEPTH));
endmodule

// File: rtl/dcache_write_buffer.sv
// Posted-write buffer between the write-through DCache and the memory bus:
// 1-cycle store completion, in-order drain, store-to-load forwarding, read bypass.
module dcache_write_buffer
  import mem_if_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  dcache_write_buffer_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RD   = RD;
  localparam logic [1:0] ST_WR   = WR;
  localparam logic [1:0] ST_RSP  = RSP;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic [1:0]            state;
  logic                  resp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  mem_rd_q, mem_wr_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  logic                  full, push, pop;
  logic [PW:0]           count;
  logic [PW-1:0]         head;
  logic [DEPTH-1:0]      valid;
  entry_t [DEPTH-1:0]    entries;
  entry_t                head_entry, push_entry;

  logic                  accept, rd_pending, rd_hit, rd_miss;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [PW-1:0]         idx;

  wb_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .full       (full),
    .count      (count),
    .head       (head),
    .valid      (valid),
    .entries    (entries)
  );

  // A request still high during its own response cycle must not be taken again.
  assign accept     = !resp_q;
  assign pop        = (state == ST_WR) && bus.mem_response;
  assign push       = accept && bus.cache_write_request && (!full || pop);
  assign push_entry = '{addr: bus.cache_addr, data: bus.cache_write_data};
  assign head_entry = entries[head];

  // Writes win a simultaneous request; the read is re-evaluated once the write is done.
  assign rd_pending = accept && bus.cache_read_request && !bus.cache_write_request;
  assign rd_hit     = rd_pending && fwd_hit && (state == ST_IDLE || state == ST_WR);
  assign rd_miss    = rd_pending && !fwd_hit && (state == ST_IDLE);

  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (valid[idx] &&
          entries[idx].addr[ADDR_WIDTH-1:WORD_LSB] == bus.cache_addr[ADDR_WIDTH-1:WORD_LSB]) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[idx].data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      resp_q      <= 1'b0;
      rdata_q     <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      resp_q <= push || rd_hit;
      if (rd_hit) rdata_q <= fwd_data;
      case (state)
        ST_IDLE: begin
          if (rd_miss) begin
            state      <= ST_RD;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= bus.cache_addr;
          end else if (count != '0) begin
            state       <= ST_WR;
            mem_wr_q    <= 1'b1;
            mem_addr_q  <= head_entry.addr;
            mem_wdata_q <= head_entry.data;
          end
        end
        ST_RD: begin
          if (bus.mem_response) begin
            mem_rd_q <= 1'b0;
            rdata_q  <= bus.mem_read_data;
            state    <= ST_RSP;
          end
        end
        ST_WR: begin
          if (bus.mem_response) begin
            mem_wr_q <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_RSP: begin
          resp_q <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cache_response    = resp_q;
  assign bus.cache_read_data   = rdata_q;
  assign bus.mem_read_request  = mem_rd_q;
  assign bus.mem_write_request = mem_wr_q;
  assign bus.mem_addr          = mem_addr_q;
  assign bus.mem_write_data    = mem_wdata_q;
  assign bus.empty             = (count == '0) && (state == ST_IDLE);
endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed bench for dcache_write_buffer: a scripted cache master plus a
// memory responder that logs every completed memory transaction in order.
module tb_dcache_write_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_write_buffer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  dcache_write_buffer #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        log_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  bit          mem_en      = 1'b0;
  logic [31:0] rd_value    = 32'h0;

  int          cyc;
  logic [31:0] rdat;
  bit          saw;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory responds one cycle after a request is seen, only while enabled.
  always @(negedge clk) begin
    bus.mem_response  = 1'b0;
    bus.mem_read_data = 32'h0;
    if (bus.mem_read_request || bus.mem_write_request) begin
      vectors++;
      assert (!(bus.mem_read_request && bus.mem_write_request)) else begin
        miscompares++;
        $error("FAIL mem_excl: observed rd=1 wr=1 expected at most one");
      end
      if (mem_en) begin
        bus.mem_response = 1'b1;
        if (bus.mem_read_request) bus.mem_read_data = rd_value;
        log_q.push_back('{wr: bus.mem_write_request, addr: bus.mem_addr, data: bus.mem_write_data});
      end
    end
  end

  task automatic set_mem(input bit v);
    @(posedge clk);
    mem_en = v;
    @(negedge clk);
  endtask

  // Write held through its response cycle, dropped the cycle after.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int max, output int c);
    bus.cache_write_request = 1'b1;
    bus.cache_addr          = a;
    bus.cache_write_data    = d;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!bus.cache_response && c < max);
    @(negedge clk);
    bus.cache_write_request = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input int max, output int c,
                         output logic [31:0] d, output bit s);
    bus.cache_read_request = 1'b1;
    bus.cache_addr         = a;
    c = 0;
    s = 1'b0;
    do begin
      @(negedge clk);
      c++;
      if (bus.mem_read_request) s = 1'b1;
    end while (!bus.cache_response && c < max);
    d = bus.cache_read_data;
    bus.cache_read_request = 1'b0;
  endtask

  task automatic wait_empty(input string tag, input int max);
    int n = 0;
    @(negedge clk);
    while (!bus.empty && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, bus.empty, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    bus.cache_read_request  = 1'b0;
    bus.cache_write_request = 1'b0;
    bus.cache_addr          = 32'h0;
    bus.cache_write_data    = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_empty", bus.empty, 1);
    chk("rst_resp", bus.cache_response, 0);
    chk("rst_mrd", bus.mem_read_request, 0);
    chk("rst_mwr", bus.mem_write_request, 0);
    chk("rst_maddr", bus.mem_addr, 0);
    chk("rst_rdata", bus.cache_read_data, 0);
    rst = 1'b0;
    set_mem(1);

    // Single write drains to memory
    do_write(32'h100, 32'hDEAD, 20, cyc);
    chk("t1_lat", cyc, 1);
    wait_empty("t1_empty", 20);
    chk("t1_n", log_q.size(), 1);
    chk("t1_kind", log_q[0].wr, 1);
    chk("t1_addr", log_q[0].addr, 32'h100);
    chk("t1_data", log_q[0].data, 32'hDEAD);
    log_q.delete();

    // Five writes into a 4-deep buffer with memory stalled
    set_mem(0);
    for (int i = 0; i < 4; i++) begin
      do_write(32'h400 + 32'(4 * i), 32'(i + 1), 20, cyc);
      chk("t2_lat", cyc, 1);
    end
    fork
      do_write(32'h410, 32'd5, 40, cyc);
      begin
        repeat (5) @(negedge clk);
        @(posedge clk);
        mem_en = 1'b1;
      end
    join
    chk("t2_stall_lat", cyc, 7);
    wait_empty("t2_empty", 40);
    chk("t2_n", log_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("t2_addr", log_q[i].addr, 32'h400 + 32'(4 * i));
      chk("t2_data", log_q[i].data, 32'(i + 1));
    end
    log_q.delete();

    // Youngest matching store forwards to a read
    set_mem(0);
    do_write(32'h200, 32'd1, 20, cyc);
    do_write(32'h200, 32'd2, 20, cyc);
    do_read(32'h202, 20, cyc, rdat, saw);
    chk("t3_lat", cyc, 1);
    chk("t3_data", rdat, 32'd2);
    chk("t3_nomem", saw, 0);
    set_mem(1);
    wait_empty("t3_empty", 40);
    chk("t3_n", log_q.size(), 2);
    chk("t3_d0", log_q[0].data, 32'd1);
    chk("t3_d1", log_q[1].data, 32'd2);
    log_q.delete();

    // Unmatched read bypasses queued stores
    set_mem(0);
    do_write(32'h500, 32'hA, 20, cyc);
    do_write(32'h104, 32'hB, 20, cyc);
    do_write(32'h108, 32'hC, 20, cyc);
    rd_value = 32'h55;
    fork
      do_read(32'h300, 40, cyc, rdat, saw);
      begin
        repeat (3) @(negedge clk);
        @(posedge clk);
        mem_en = 1'b1;
      end
    join
    chk("t4_done", cyc < 40, 1);
    chk("t4_data", rdat, 32'h55);
    chk("t4_mem", saw, 1);
    wait_empty("t4_empty", 40);
    chk("t4_n", log_q.size(), 4);
    chk("t4_k0", log_q[0].wr, 1);
    chk("t4_a0", log_q[0].addr, 32'h500);
    chk("t4_k1", log_q[1].wr, 0);
    chk("t4_a1", log_q[1].addr, 32'h300);
    chk("t4_a2", log_q[2].addr, 32'h104);
    chk("t4_a3", log_q[3].addr, 32'h108);
    chk("t4_d3", log_q[3].data, 32'hC);
    log_q.delete();

    // Reset in the middle of a drain
    set_mem(0);
    do_write(32'h600, 32'd6, 20, cyc);
    do_write(32'h604, 32'd7, 20, cyc);
    do_write(32'h608, 32'd8, 20, cyc);
    chk("t5_pre_mwr", bus.mem_write_request, 1);
    chk("t5_pre_addr", bus.mem_addr, 32'h600);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_mwr", bus.mem_write_request, 0);
    chk("t5_empty", bus.empty, 1);
    rst = 1'b0;
    rd_value = 32'h77;
    set_mem(1);
    do_read(32'h600, 20, cyc, rdat, saw);
    chk("t5_mem", saw, 1);
    chk("t5_data", rdat, 32'h77);
    repeat (5) @(negedge clk);
    chk("t5_n", log_q.size(), 1);
    chk("t5_kind", log_q[0].wr, 0);
    log_q.delete();

    // Write held through its response cycle is pushed once
    set_mem(0);
    do_write(32'h10, 32'h99, 20, cyc);
    chk("t6_lat", cyc, 1);
    repeat (3) @(negedge clk);
    chk("t6_mwr", bus.mem_write_request, 1);
    chk("t6_addr", bus.mem_addr, 32'h10);
    chk("t6_wdata", bus.mem_write_data, 32'h99);
    set_mem(1);
    wait_empty("t6_empty", 20);
    repeat (4) @(negedge clk);
    chk("t6_still_empty", bus.empty, 1);
    chk("t6_n", log_q.size(), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
